my_module_pipe: RTL and testbench



---
 rtl/my_module_pipe.sv | 62 ++++++
 tb/tb_my_module_pipe.sv | 129 ++++++++++++
 2 files changed

// File: rtl/my_module_pipe.sv
// Fixed-latency register pipeline for my_module: DEPTH stages of WIDTH-bit data,
// plus a saturating fill counter that raises valid once the chain holds real samples.
module my_module_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int          DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  // Clamped copies keep declarations well-formed while the range check reports the error.
  localparam int unsigned STAGES = (DEPTH < 1) ? 1 : DEPTH;
  localparam int unsigned FILL_W = $clog2(STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(STAGES);

  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
    $error("my_module_pipe: DEPTH=%0d outside legal range 1..16", DEPTH);
  end

  logic [WIDTH-1:0]  stage_q [STAGES];
  logic [WIDTH-1:0]  stage_d [STAGES];
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              valid_q;
  logic              valid_d;

  // Next-state: shift the chain, saturate the fill count, flag when full.
  always_comb begin
    stage_d[0] = data_in;
    for (int i = 1; i < int'(STAGES); i++) begin
      stage_d[i] = stage_q[i-1];
    end
    fill_d = fill_q;
    if (fill_q < FILL_MAX) begin
      fill_d = fill_q + FILL_W'(1);
    end
    valid_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = stage_q[STAGES-1];
  assign valid    = valid_q;

endmodule

// File: tb/tb_my_module_pipe.sv
// Bench for my_module_pipe at DEPTH 1, 2 and 16, checked against a sample-history model.
module tb_my_module_pipe;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] dout_d1, dout_d2, dout_d16;
  logic       valid_d1, valid_d2, valid_d16;

  int checks;
  int errors;

  // Every word sampled on a non-reset edge since the last reset, oldest first.
  logic [7:0] hist [$];

  my_module_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_d1), .valid(valid_d1)
  );
  my_module_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_d2), .valid(valid_d2)
  );
  my_module_pipe #(.WIDTH(8), .DEPTH(16)) u_d16 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_d16), .valid(valid_d16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After k clean edges, depth D shows the sample taken D-1 edges ago (k-D in 0-based history).
  function automatic logic [7:0] exp_data(input int d);
    int k;
    k = hist.size();
    return (k >= d) ? hist[k-d] : 8'h00;
  endfunction

  function automatic logic exp_valid(input int d);
    return hist.size() >= d;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("d1_data",   dout_d1,            exp_data(1));
    check("d1_valid",  {7'b0, valid_d1},   {7'b0, exp_valid(1)});
    check("d2_data",   dout_d2,            exp_data(2));
    check("d2_valid",  {7'b0, valid_d2},   {7'b0, exp_valid(2)});
    check("d16_data",  dout_d16,           exp_data(16));
    check("d16_valid", {7'b0, valid_d16},  {7'b0, exp_valid(16)});
  endtask

  // Drive one edge's inputs, let the edge happen, update the model, compare.
  task automatic step(input logic r, input logic [7:0] d);
    @(negedge clk);
    reset   = r;
    data_in = d;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else   hist.push_back(d);
    check_all();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    data_in = 8'h00;

    // Reset values held over two edges
    step(1'b1, 8'h5C);
    step(1'b1, 8'h5C);
    check("rst_d2_data", dout_d2, 8'h00);

    // Basic passthrough: E1 clean, AA on E2, visible after E3 at depth 2
    step(1'b0, 8'h00);
    check("e1_d2_valid_low", {7'b0, valid_d2}, 8'h00);
    step(1'b0, 8'hAA);
    check("e2_d2_valid_high", {7'b0, valid_d2}, 8'h01);
    step(1'b0, 8'($urandom));
    check("pass_d2_aa", dout_d2, 8'hAA);
    step(1'b0, 8'($urandom));

    // Ordered stream with no gaps
    step(1'b0, 8'h01);
    step(1'b0, 8'h02);
    check("ord_d2_01", dout_d2, 8'h01);
    step(1'b0, 8'h03);
    check("ord_d2_02", dout_d2, 8'h02);
    step(1'b0, 8'hFF);
    check("ord_d2_03", dout_d2, 8'h03);
    step(1'b0, 8'($urandom));
    check("ord_d2_ff", dout_d2, 8'hFF);
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom));

    // Single-edge reset mid-stream; the word on the reset edge is dropped
    for (int i = 0; i < 8; i++) step(1'b0, 8'(8'h10 + i));
    step(1'b1, 8'h18);
    check("mid_rst_d2_data", dout_d2, 8'h00);
    step(1'b0, 8'h20);
    check("mid_e1_d2_not18", dout_d2, 8'h00);
    step(1'b0, 8'h21);
    check("mid_e2_d2_valid", {7'b0, valid_d2}, 8'h01);
    check("mid_e2_d2_data", dout_d2, 8'h20);

    // Depth sweep: C3 on E1 emerges DEPTH-1 edges later
    step(1'b1, 8'h00);
    step(1'b0, 8'hC3);
    check("sweep_d1_c3", dout_d1, 8'hC3);
    for (int i = 0; i < 15; i++) step(1'b0, 8'(i));
    check("sweep_d16_c3", dout_d16, 8'hC3);
    check("sweep_d16_valid", {7'b0, valid_d16}, 8'h01);
    step(1'b0, 8'h00);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
